// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit stages.
//   rx_state_e      receiver FSM state encoding
//   STATE_*         bit positions inside the 8-bit status word
//   even_parity()   XOR reduction of a data byte (even-parity bit value)
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  localparam int STATE_BUSY    = 0;
  localparam int STATE_VALID   = 1;
  localparam int STATE_FRAME   = 2;
  localparam int STATE_OVERRUN = 3;
  localparam int STATE_PARITY  = 4;

  // Parity bit that makes the total number of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
//   clk     system clock
//   resetn  asynchronous active-low reset; both flops reset to 1 (idle line)
//   din     asynchronous input
//   dout    input re-timed to clk, two cycles of latency
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (idle high, 1 start bit, 8 data bits LSB first,
// optional even parity bit, 1 stop bit) with a valid/ready byte output and
// sticky error flags.
//   Parameter CLKS_PER_BIT  bit period in clk cycles (even, >= 4)
//   clk      system clock
//   resetn   asynchronous active-low reset
//   pin      asynchronous serial input, idle high
//   data     received byte, stable while valid=1
//   valid    byte available
//   ready    consumer accepts the byte when valid & ready
//   err_clr  clears the sticky error flags (a new error in the same cycle wins)
//   state    {3'b0, parity_err, overrun, framing_err, valid, busy}
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after
// bit 7; otherwise the frame is 10 bits and parity_err is tied to 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pin,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  input  logic       err_clr,
  output logic [7:0] state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx;
  rx_state_e        fsm;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             framing_err;
  logic             overrun;
  logic             parity_err;
  logic             busy;

  logic tick_half;
  logic tick_full;
  logic stop_sample;
  logic deliver;
  logic frame_set;
  logic parity_set;

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (pin),
    .dout   (rx)
  );

  assign tick_half   = (cnt == HALF_M1);
  assign tick_full   = (cnt == FULL_M1);
  assign stop_sample = (fsm == S_STOP) && tick_full;
  // A finished byte is accepted if the output slot is empty or is being
  // emptied in this very cycle; otherwise it is dropped as an overrun.
  assign deliver     = stop_sample && (!valid || ready);
  assign frame_set   = stop_sample && !rx;

`ifdef UART_RX_PARITY_EN
  assign parity_set = (fsm == S_PARITY) && tick_full && (rx != even_parity(shift));
`else
  assign parity_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm         <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      // Output slot and sticky flags
      if (deliver) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      overrun     <= (stop_sample && !deliver) | (overrun & ~err_clr);
      framing_err <= frame_set | (framing_err & ~err_clr);
      parity_err  <= parity_set | (parity_err & ~err_clr);

      // Frame sequencing
      case (fsm)
        S_IDLE: begin
          cnt <= '0;
          if (!rx) fsm <= S_START;
        end
        S_START: begin
          if (tick_half) begin
            cnt     <= '0;
            bit_idx <= '0;
            fsm     <= rx ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_full) begin
            cnt   <= '0;
            shift <= {rx, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              fsm <= S_PARITY;
`else
              fsm <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_full) begin
            cnt <= '0;
            fsm <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Back to IDLE straight after the sample; a held-low line starts
          // a new frame from there.
          if (tick_full) begin
            cnt <= '0;
            fsm <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
          fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (fsm != S_IDLE);

  always_comb begin
    state                = 8'h00;
    state[STATE_BUSY]    = busy;
    state[STATE_VALID]   = valid;
    state[STATE_FRAME]   = framing_err;
    state[STATE_OVERRUN] = overrun;
    state[STATE_PARITY]  = parity_err;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with N = 16.
module tb_uart_rx;

  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EXTRA = N;
`else
  localparam int PAR_EXTRA = 0;
`endif
  // Pin-low to valid-visible: 2 synchroniser cycles + 153 cycles from T0.
  localparam int RISE_OFF = 2 + 153 + PAR_EXTRA;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pin = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] state;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       valid_prev = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pin     (pin),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .err_clr (err_clr),
    .state   (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      rise_cnt  = rise_cnt + 1;
      rise_cyc  = cyc;
      rise_data = data;
    end
    valid_prev = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drives one frame starting at a negedge; returns N*(10 or 11) negedges later.
  // A low stop bit is held only long enough to be sampled, so the line is
  // high again before the receiver goes back to IDLE.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_bit, output int t0);
    t0  = cyc;
    pin = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      repeat (N) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    pin = par_bit;
    repeat (N) @(negedge clk);
`else
    if (par_bit) pin = 1'b1; // no parity slot in this build
`endif
    pin = stop_bit;
    if (!stop_bit) begin
      repeat (9) @(negedge clk);
      pin = 1'b1;
      repeat (N - 9) @(negedge clk);
    end else begin
      repeat (N) @(negedge clk);
    end
    pin = 1'b1;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_frame;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0;
    int rc;

    vecs[0] = '{b: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_frame: 1'b0};
    vecs[1] = '{b: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_frame: 1'b0};
    vecs[2] = '{b: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_frame: 1'b0};
    vecs[3] = '{b: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_frame: 1'b1};
    vecs[4] = '{b: 8'h81, stop: 1'b1, exp_data: 8'h81, exp_frame: 1'b0};

    // Reset and idle line
    repeat (3) @(negedge clk);
    chk("reset_state", {24'h0, state}, 32'h00);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_valid", {31'h0, valid}, 32'h0);
    chk("idle_state", {24'h0, state}, 32'h00);
    chk("idle_data", {24'h0, data}, 32'h00);

    // Table-driven frames, consumer always ready
    ready = 1'b1;
    foreach (vecs[i]) begin
      rc = rise_cnt;
      send_frame(vecs[i].b, vecs[i].stop, ^vecs[i].b, t0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_rise", i), rise_cnt, rc + 1);
      chk($sformatf("v%0d_latency", i), rise_cyc - t0, RISE_OFF);
      chk($sformatf("v%0d_data", i), {24'h0, rise_data}, {24'h0, vecs[i].exp_data});
      chk($sformatf("v%0d_valid_dropped", i), {31'h0, valid}, 32'h0);
      chk($sformatf("v%0d_frame", i), {31'h0, state[2]}, {31'h0, vecs[i].exp_frame});
      chk($sformatf("v%0d_overrun", i), {31'h0, state[3]}, 32'h0);
      if (vecs[i].exp_frame) begin
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_frame_sticky", i), {31'h0, state[2]}, 32'h1);
        pulse_err_clr();
        chk($sformatf("v%0d_frame_cleared", i), {24'h0, state}, 32'h00);
      end
      repeat (4) @(negedge clk);
    end
    ready = 1'b0;

    // Short low glitch: false start, nothing reported
    rc  = rise_cnt;
    pin = 1'b0;
    repeat (4) @(negedge clk);
    pin = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_valid", rise_cnt, rc);
    chk("glitch_state", {24'h0, state}, 32'h00);

    // Two frames with no consumer: second one overruns
    send_frame(8'h11, 1'b1, ^8'h11, t0);
    send_frame(8'h22, 1'b1, ^8'h22, t0);
    repeat (2) @(negedge clk);
    chk("ovr_data_kept", {24'h0, data}, 32'h11);
    chk("ovr_state", {24'h0, state}, 32'h0A);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #1;
    chk("ovr_valid_drop", {31'h0, valid}, 32'h0);
    chk("ovr_data_after_drop", {24'h0, data}, 32'h11);
    pulse_err_clr();
    chk("ovr_cleared", {24'h0, state}, 32'h00);

    // Ready coinciding with the second stop sample: no overrun
    send_frame(8'h11, 1'b1, ^8'h11, t0);
    fork
      send_frame(8'h22, 1'b1, ^8'h22, t0);
      begin
        repeat (RISE_OFF - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk("coin_data", {24'h0, data}, 32'h22);
        chk("coin_state", {24'h0, state}, 32'h02);
      end
    join
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);

`ifdef UART_RX_PARITY_EN
    ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0, t0);
    repeat (2) @(negedge clk);
    chk("par_bad_flag", {31'h0, state[4]}, 32'h1);
    chk("par_bad_data", {24'h0, data}, 32'h07);
    pulse_err_clr();
    send_frame(8'h07, 1'b1, 1'b1, t0);
    repeat (2) @(negedge clk);
    chk("par_good_flag", {24'h0, state}, 32'h00);
    ready = 1'b0;
`endif

    // Reset in the middle of a frame
    pin = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_busy_before", {31'h0, state[0]}, 32'h1);
    resetn = 1'b0;
    pin    = 1'b1;
    #1;
    chk("midrst_state", {24'h0, state}, 32'h00);
    chk("midrst_data", {24'h0, data}, 32'h00);
    @(negedge clk);
    resetn = 1'b1;
    rc = rise_cnt;
    repeat (40) @(negedge clk);
    chk("midrst_no_valid", rise_cnt, rc);
    chk("midrst_idle", {24'h0, state}, 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
